fp32_stream_accumulator: RTL and testbench
==========================================

Name: fp32_stream_accumulator

Overview:
Sequential FP32 accumulator in the CPU core's FPU. It sums a stream of IEEE-754 single-precision operands into one frame result, for example summing weighted spikes into a membrane potential. It drives the core's combinational FP32 add/sub unit (ports a_operand, b_operand, AddBar_Sub, result, Exception) and registers that unit's output. Results go downstream over a valid/ready handshake.

Parameters:
CNT_W, 8, width of the per-frame element counter; the counter saturates at 2^CNT_W-1.

Ports:
CLK  input  1  clock; all state updates on the rising edge
RESET  input  1  synchronous, active-high reset
clear  input  1  synchronous abort of the current frame; RESET has priority over clear
in_valid  input  1  input operand valid
in_ready  output  1  accumulator can accept an operand this cycle
in_data  input  32  FP32 operand
in_sub  input  1  1 = subtract in_data from the accumulator, 0 = add it
in_last  input  1  operand is the final element of the frame
out_valid  output  1  frame result valid
out_ready  input  1  downstream accepts the result
out_data  output  32  FP32 frame sum
out_count  output  CNT_W  elements accumulated in the frame (saturating)
out_exception  output  1  sticky: some add in the frame raised the adder Exception

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high.
- Internal registers: state, acc[31:0], op_reg[31:0], sub_reg, last_reg, cnt[CNT_W-1:0], exc_sticky.
- Adder hookup: a_operand=acc, b_operand=op_reg, AddBar_Sub=sub_reg. The adder is purely combinational; its output is sampled only in the ADD state.
- Reset values: state=ACCEPT, acc=32'h0, op_reg=0, sub_reg=0, last_reg=0, cnt=0, exc_sticky=0. Outputs after reset: in_ready=1, out_valid=0, out_data=0, out_count=0, out_exception=0.
- Output decode: in_ready=(state==ACCEPT); out_valid=(state==DONE). out_data, out_count and out_exception are driven continuously from acc, cnt and exc_sticky.
- State ACCEPT: on in_valid&in_ready, capture op_reg<=in_data, sub_reg<=in_sub, last_reg<=in_last, then go to ADD. Without in_valid, stay in ACCEPT.
- State ADD (exactly one cycle; in_ready=0):
  - acc<=adder result;
  - exc_sticky<=exc_sticky|adder Exception;
  - cnt<=cnt+1, held at all-ones once saturated;
  - next state is DONE if last_reg, else ACCEPT.
- State DONE: hold all outputs stable while out_ready=0. On out_ready: acc<=0, cnt<=0, exc_sticky<=0, go to ACCEPT.
- Throughput and latency:
  - one operand per 2 cycles;
  - the last operand is accepted at cycle T, and out_valid rises at T+2;
  - the earliest next accept is the cycle after the output handshake.
- Frames always hold at least one element; an empty frame is not possible.
- Arithmetic: results exactly as the adder produces them (truncating, no rounding). If Exception is asserted, the adder result is 0, so acc becomes 0 and the flag stays sticky until the frame completes.
- clear (without RESET), in any state: acc, cnt, exc_sticky, op_reg and last_reg cleared; go to ACCEPT. A pending DONE result is discarded. An in_valid in the same cycle is not accepted.
- RESET in any state, including mid-ADD or DONE with out_ready high: the reset values apply next cycle. No output handshake completes in that cycle.
- in_data, in_sub and in_last are sampled only on an accept; they are ignored when in_ready=0.

Test Plan:
- Add frame: after reset, stream 0x3F800000, 0x40000000, 0x3F000000 (last), all add, out_ready=1 → out_valid 2 cycles after the last accept; out_data=0x40600000 (3.5), out_count=3, out_exception=0.
- Subtract: stream 0x40A00000 (add), 0x40000000 (sub, last) → out_data=0x40400000 (3.0), out_count=2.
- Exception: stream 0x3F800000, 0x7F800000, 0x3F800000 (last) → out_exception=1, out_data=0x3F800000, out_count=3. The next frame 0x3F800000 (last) gives out_exception=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid and outputs stable, in_ready=0 throughout. Raise out_ready → the next cycle shows in_ready=1, out_valid=0.
- Saturation: with CNT_W=2, a frame of 5 × 0x3F800000 → out_count=3, out_data=0x40A00000.
- Abort: assert RESET during ADD (and separately, clear during DONE) → the next cycle shows in_ready=1, out_valid=0, and a following single-element frame 0x40000000 gives out_data=0x40000000, out_count=1.

Source files
------------

// File: rtl/fp32_stream_accumulator.sv
// fp32_stream_accumulator
//   Sums a stream of IEEE-754 single-precision operands into one result per
//   frame. Each operand is registered in one cycle and folded into the
//   accumulator through a combinational FP32 add/sub unit in the next cycle.
//   The frame result is held on a valid/ready handshake until it is taken.
//
//   Ports:
//     CLK, RESET            clock, synchronous active-high reset
//     clear                 synchronous abort of the current frame
//     in_valid / in_ready   operand handshake
//     in_data               FP32 operand
//     in_sub                1 = subtract operand, 0 = add
//     in_last               operand closes the frame
//     out_valid / out_ready result handshake
//     out_data              FP32 frame sum
//     out_count             elements in the frame, saturating at 2^CNT_W-1
//     out_exception         some add in the frame raised the adder exception
//
// fp32_add_sub
//   Combinational FP32 adder/subtractor. Truncates (rounds toward zero),
//   flushes subnormal operands and underflowing results to +0, and raises
//   Exception for Inf/NaN operands or exponent overflow, in which case the
//   result is forced to 0.
//
//   Ports: a_operand, b_operand (FP32), AddBar_Sub (1 = a - b),
//          result (FP32), Exception.

module fp32_add_sub (
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic        AddBar_Sub,
  output logic [31:0] result,
  output logic        Exception
);

  logic [7:0]        e_a, e_b, e_big, e_small, e_diff;
  logic [23:0]       m_a, m_b, m_big, m_small;
  logic              s_a, s_b, s_big, eff_sub, a_is_big, special;
  logic [26:0]       big_ext, small_ext, small_shift, sticky_mask;
  logic              sticky;
  logic [27:0]       mag_sum, norm;
  logic [4:0]        lead, shamt;
  logic signed [9:0] exp_res;
  logic              norm_unused;

  // Align the smaller operand to the larger one (keeping three guard bits and
  // a sticky bit so truncation of a subtraction still rounds toward zero),
  // add or subtract the magnitudes, then renormalise around bit 26.
  always_comb begin
    e_a         = a_operand[30:23];
    e_b         = b_operand[30:23];
    m_a         = (e_a != 8'd0) ? {1'b1, a_operand[22:0]} : 24'd0;
    m_b         = (e_b != 8'd0) ? {1'b1, b_operand[22:0]} : 24'd0;
    s_a         = a_operand[31];
    s_b         = b_operand[31] ^ AddBar_Sub;
    special     = (&e_a) | (&e_b);
    a_is_big    = (a_operand[30:0] >= b_operand[30:0]);
    e_big       = a_is_big ? e_a : e_b;
    e_small     = a_is_big ? e_b : e_a;
    m_big       = a_is_big ? m_a : m_b;
    m_small     = a_is_big ? m_b : m_a;
    s_big       = a_is_big ? s_a : s_b;
    eff_sub     = s_a ^ s_b;
    e_diff      = e_big - e_small;
    big_ext     = {m_big, 3'b000};
    small_ext   = {m_small, 3'b000};
    small_shift = 27'd0;
    sticky_mask = 27'd0;
    sticky      = 1'b0;
    lead        = 5'd0;
    shamt       = 5'd0;
    norm        = 28'd0;
    exp_res     = 10'sd0;
    result      = 32'd0;

    if (e_diff >= 8'd27) begin
      sticky = |small_ext;
    end else begin
      small_shift = small_ext >> e_diff;
      sticky_mask = (27'd1 << e_diff) - 27'd1;
      sticky      = |(small_ext & sticky_mask);
    end
    small_shift[0] = small_shift[0] | sticky;

    mag_sum = eff_sub ? ({1'b0, big_ext} - {1'b0, small_shift})
                      : ({1'b0, big_ext} + {1'b0, small_shift});

    for (int i = 0; i < 28; i++) begin
      if (mag_sum[i]) lead = i[4:0];
    end

    if (mag_sum[27]) begin
      norm    = mag_sum >> 1;
      exp_res = $signed({2'b00, e_big}) + 10'sd1;
    end else begin
      shamt   = 5'd26 - lead;
      norm    = mag_sum << shamt;
      exp_res = $signed({2'b00, e_big}) - $signed({5'b00000, shamt});
    end

    Exception = special | ((mag_sum != 28'd0) && (exp_res >= 10'sd255));

    // Exact cancellation and underflow both give +0.
    if (!Exception && (mag_sum != 28'd0) && (exp_res > 10'sd0))
      result = {s_big, exp_res[7:0], norm[25:3]};
  end

  assign norm_unused = ^{norm[27:26], norm[2:0]};

endmodule

module fp32_stream_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_exception
);

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    ADD    = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state;
  logic [31:0]       acc;
  logic [31:0]       op_reg;
  logic              sub_reg;
  logic              last_reg;
  logic [CNT_W-1:0]  cnt;
  logic              exc_sticky;
  logic [31:0]       add_result;
  logic              add_exc;

  fp32_add_sub u_add_sub (
    .a_operand (acc),
    .b_operand (op_reg),
    .AddBar_Sub(sub_reg),
    .result    (add_result),
    .Exception (add_exc)
  );

  // Frame control: capture an operand, fold it in during the following cycle,
  // and park in DONE until the result is taken. RESET beats clear, and clear
  // beats any handshake in the same cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ACCEPT;
      acc        <= 32'd0;
      op_reg     <= 32'd0;
      sub_reg    <= 1'b0;
      last_reg   <= 1'b0;
      cnt        <= '0;
      exc_sticky <= 1'b0;
    end else if (clear) begin
      state      <= ACCEPT;
      acc        <= 32'd0;
      op_reg     <= 32'd0;
      last_reg   <= 1'b0;
      cnt        <= '0;
      exc_sticky <= 1'b0;
    end else begin
      case (state)
        ACCEPT: begin
          if (in_valid) begin
            op_reg   <= in_data;
            sub_reg  <= in_sub;
            last_reg <= in_last;
            state    <= ADD;
          end
        end
        ADD: begin
          acc        <= add_result;
          exc_sticky <= exc_sticky | add_exc;
          if (cnt != {CNT_W{1'b1}})
            cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          state <= last_reg ? DONE : ACCEPT;
        end
        DONE: begin
          if (out_ready) begin
            acc        <= 32'd0;
            cnt        <= '0;
            exc_sticky <= 1'b0;
            state      <= ACCEPT;
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end

  assign in_ready      = (state == ACCEPT);
  assign out_valid     = (state == DONE);
  assign out_data      = acc;
  assign out_count     = cnt;
  assign out_exception = exc_sticky;

endmodule

// File: tb/tb_fp32_stream_accumulator.sv
// tb_fp32_stream_accumulator
//   Directed and randomised frames for fp32_stream_accumulator (CNT_W = 2 so
//   count saturation is reachable). The reference model keeps the running sum
//   as an exact integer count of quarters and converts it to FP32 bits only
//   when a result is compared; all operands are chosen so the sum is exactly
//   representable and truncation cannot change it.

module tb_fp32_stream_accumulator;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_sub;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [CNT_W-1:0] out_count;
  logic             out_exception;

  int checks = 0;
  int fails  = 0;

  int model_q;
  int model_n;
  bit model_exc;

  fp32_stream_accumulator #(.CNT_W(CNT_W)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_sub       (in_sub),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_count    (out_count),
    .out_exception(out_exception)
  );

  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Signed number of quarters -> FP32 bits (|q| < 2^23).
  function automatic logic [31:0] toFp(input int q);
    int mag;
    int p;
    logic [31:0] r;
    if (q == 0) return 32'd0;
    mag = (q < 0) ? -q : q;
    p = 0;
    for (int i = 0; i < 31; i++) if (mag[i]) p = i;
    r[31]    = (q < 0);
    r[30:23] = 8'(127 + p - 2);
    r[22:0]  = 23'((mag << (23 - p)) & 32'h007F_FFFF);
    return r;
  endfunction

  // FP32 bits -> signed number of quarters (finite values that are multiples of 0.25).
  function automatic int fromFp(input logic [31:0] b);
    int m;
    int sh;
    int q;
    if (b[30:23] == 8'd0) return 0;
    m  = int'({1'b1, b[22:0]});
    sh = int'(b[30:23]) - 148;
    q  = (sh >= 0) ? (m << sh) : (m >> (-sh));
    return b[31] ? -q : q;
  endfunction

  task automatic resetModel();
    model_q   = 0;
    model_n   = 0;
    model_exc = 0;
  endtask

  task automatic modelApply(input logic [31:0] d, input logic s);
    model_n++;
    if (d[30:23] == 8'hFF) begin
      model_q   = 0;
      model_exc = 1;
    end else if (s) begin
      model_q = model_q - fromFp(d);
    end else begin
      model_q = model_q + fromFp(d);
    end
  endtask

  // Offers one operand, waits for it to be taken, keeps garbage on the inputs
  // during the busy cycle, and checks the handshake timing that follows.
  task automatic applyStimulus(input logic [31:0] d, input logic s, input logic l);
    int waitCycles = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_sub   = s;
    in_last  = l;
    while (in_ready !== 1'b1 && waitCycles < 20) begin
      tick();
      waitCycles++;
    end
    checkOutput("accept_ready", 32'(in_ready), 32'd1);
    tick();
    modelApply(d, s);
    in_data = $urandom;
    in_sub  = 1'($urandom_range(0, 1));
    in_last = 1'($urandom_range(0, 1));
    checkOutput("add_busy", 32'(in_ready), 32'd0);
    checkOutput("add_no_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    if (l) checkOutput("done_latency", 32'(out_valid), 32'd1);
    else   checkOutput("next_ready", 32'(in_ready), 32'd1);
  endtask

  // Checks the held result, stalls for 'hold' cycles, then takes it.
  task automatic collectResult(input logic [31:0] expData, input int expCount,
                               input logic expExc, input int hold);
    out_ready = 1'b0;
    checkOutput("out_valid", 32'(out_valid), 32'd1);
    checkOutput("out_data", out_data, expData);
    checkOutput("out_count", 32'(out_count), 32'(expCount));
    checkOutput("out_exception", 32'(out_exception), 32'(expExc));
    for (int i = 0; i < hold; i++) begin
      tick();
      checkOutput("hold_valid", 32'(out_valid), 32'd1);
      checkOutput("hold_busy", 32'(in_ready), 32'd0);
      checkOutput("hold_data", out_data, expData);
      checkOutput("hold_count", 32'(out_count), 32'(expCount));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("post_ready", 32'(in_ready), 32'd1);
    checkOutput("post_valid", 32'(out_valid), 32'd0);
    checkOutput("post_data", out_data, 32'd0);
    checkOutput("post_count", 32'(out_count), 32'd0);
    checkOutput("post_exception", 32'(out_exception), 32'd0);
    resetModel();
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_data"}, out_data, 32'd0);
    checkOutput({tag, "_count"}, 32'(out_count), 32'd0);
    checkOutput({tag, "_exception"}, 32'(out_exception), 32'd0);
  endtask

  initial begin
    RESET     = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    in_sub    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    resetModel();
    repeat (3) tick();
    RESET = 1'b0;
    checkIdle("reset");

    // Add frame, stalled for ten cycles in DONE.
    applyStimulus(32'h3F80_0000, 1'b0, 1'b0);
    applyStimulus(32'h4000_0000, 1'b0, 1'b0);
    applyStimulus(32'h3F00_0000, 1'b0, 1'b1);
    collectResult(32'h4060_0000, 3, 1'b0, 10);

    // Subtract frame.
    applyStimulus(32'h40A0_0000, 1'b0, 1'b0);
    applyStimulus(32'h4000_0000, 1'b1, 1'b1);
    collectResult(32'h4040_0000, 2, 1'b0, 0);

    // Exception clears the sum, the flag sticks, next frame is clean.
    applyStimulus(32'h3F80_0000, 1'b0, 1'b0);
    applyStimulus(32'h7F80_0000, 1'b0, 1'b0);
    applyStimulus(32'h3F80_0000, 1'b0, 1'b1);
    collectResult(32'h3F80_0000, 3, 1'b1, 1);
    applyStimulus(32'h3F80_0000, 1'b0, 1'b1);
    collectResult(32'h3F80_0000, 1, 1'b0, 0);

    // Count saturation.
    for (int k = 0; k < 5; k++) applyStimulus(32'h3F80_0000, 1'b0, k == 4);
    collectResult(32'h40A0_0000, CNT_MAX, 1'b0, 0);

    // RESET while an operand is being added.
    applyStimulus(32'h3F80_0000, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h4000_0000;
    in_sub   = 1'b0;
    in_last  = 1'b1;
    tick();
    in_valid = 1'b0;
    RESET    = 1'b1;
    tick();
    RESET = 1'b0;
    checkIdle("reset_add");
    resetModel();
    applyStimulus(32'h4000_0000, 1'b0, 1'b1);
    collectResult(32'h4000_0000, 1, 1'b0, 0);

    // RESET in DONE with out_ready high.
    applyStimulus(32'h4040_0000, 1'b0, 1'b1);
    out_ready = 1'b1;
    RESET     = 1'b1;
    tick();
    RESET     = 1'b0;
    out_ready = 1'b0;
    checkIdle("reset_done");
    resetModel();

    // clear in DONE discards the result and ignores a concurrent operand.
    applyStimulus(32'h3F80_0000, 1'b0, 1'b0);
    applyStimulus(32'h4040_0000, 1'b0, 1'b1);
    out_ready = 1'b1;
    clear     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h3F80_0000;
    tick();
    clear     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkIdle("clear_done");

    // clear in ACCEPT blocks the offered operand.
    in_valid = 1'b1;
    in_data  = 32'h4080_0000;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    checkIdle("clear_accept");
    resetModel();
    applyStimulus(32'h4000_0000, 1'b0, 1'b1);
    collectResult(32'h4000_0000, 1, 1'b0, 0);

    // Random frames against the model.
    for (int f = 0; f < 25; f++) begin
      int n;
      n = int'($urandom_range(1, 6));
      for (int k = 0; k < n; k++) begin
        logic [31:0] d;
        if ($urandom_range(0, 11) == 0)
          d = ($urandom_range(0, 1) == 1) ? 32'hFF80_0000 : 32'h7F80_0000;
        else
          d = toFp(int'($urandom_range(0, 4000)) - 2000);
        applyStimulus(d, 1'($urandom_range(0, 1)), k == n - 1);
      end
      collectResult(toFp(model_q), (model_n > CNT_MAX) ? CNT_MAX : model_n,
                    model_exc, int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
